// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions for the L1 instruction cache.
// Provides the line geometry, the cache controller state encoding and
// helpers that split a fetch PC into its set index and tag fields.
package fetch_pkg;

  localparam int LINE_W       = 64;
  localparam int WORD_SEL_BIT = 2;
  localparam int OFFSET_W     = 3;

  typedef enum logic [0:0] {
    LOOKUP    = 1'b0,
    MISS_WAIT = 1'b1
  } icache_state_t;

  // Set index: the bits just above the 8-byte line offset.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int index_w);
    return (pc >> OFFSET_W) & ((32'd1 << index_w) - 32'd1);
  endfunction

  // Tag: everything above offset and index.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int index_w);
    return pc >> (OFFSET_W + index_w);
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side bus of the instruction cache.
// master: PC register / instruction memory side (drives PC_F, memory block
//         words Instr_F1/Instr_F0 and countdone; receives hit_miss, StallF,
//         Instr_F and the hit/miss statistics).
// slave:  the cache itself.
interface instr_cache_if #(
  parameter int CNT_W = 16
);

  logic [31:0]      PC_F;
  logic [31:0]      Instr_F1;
  logic [31:0]      Instr_F0;
  logic             countdone;
  logic             hit_miss;
  logic             StallF;
  logic [31:0]      Instr_F;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output PC_F, Instr_F1, Instr_F0, countdone,
    input  hit_miss, StallF, Instr_F, hit_cnt, miss_cnt
  );

  modport slave (
    input  PC_F, Instr_F1, Instr_F0, countdone,
    output hit_miss, StallF, Instr_F, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/icache_array.sv
// Tag/valid/data storage of the direct-mapped instruction cache.
// Ports: clk, reset_n (async, active low, clears valid bits only);
//        rd_idx -> rd_valid/rd_tag/rd_line (combinational read);
//        wr_en/wr_idx/wr_tag/wr_line (write on posedge).
module icache_array
  import fetch_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 23
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line
);

  localparam int NUM_SETS = 1 << INDEX_W;

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];

  // Valid bits are the only storage that needs a known state after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; an invalid line is never read as a hit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped L1 instruction cache between the PC register and the
// 20-cycle instruction memory. Lines hold two instructions {word1, word0}.
// Ports: clk, reset_n (async, active low), bus (instr_cache_if.slave):
//   PC_F, Instr_F1/Instr_F0 (memory block), countdone (memory ready level)
//   -> hit_miss, StallF, Instr_F, hit_cnt, miss_cnt (saturating).
module instr_cache
  import fetch_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  instr_cache_if.slave  bus
);

  localparam int TAG_W = 32 - OFFSET_W - INDEX_W;

  localparam logic [0:0] ST_LOOKUP    = LOOKUP;
  localparam logic [0:0] ST_MISS_WAIT = MISS_WAIT;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]         state;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   cur_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [LINE_W-1:0]  rd_line;
  logic               hit;
  logic               fill;
  logic               hit_miss;
  logic [31:0]        instr;

  assign idx     = INDEX_W'(pc_index(bus.PC_F, INDEX_W));
  assign cur_tag = TAG_W'(pc_tag(bus.PC_F, INDEX_W));

  icache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill),
    .wr_idx   (idx),
    .wr_tag   (cur_tag),
    .wr_line  ({bus.Instr_F1, bus.Instr_F0})
  );

  // Zero-latency lookup plus output muxing. In the fill cycle the memory
  // block is forwarded directly, and raising hit_miss there is what parks the
  // memory counter at zero for the next miss. countdone is deliberately not
  // looked at in LOOKUP because it can still be high from the previous refill.
  always_comb begin
    hit      = rd_valid && (rd_tag == cur_tag);
    fill     = 1'b0;
    hit_miss = 1'b0;
    instr    = '0;
    if (reset_n) begin
      if (state == ST_LOOKUP) begin
        if (hit) begin
          hit_miss = 1'b1;
          instr    = bus.PC_F[WORD_SEL_BIT] ? rd_line[63:32] : rd_line[31:0];
        end
      end else if (bus.countdone) begin
        fill     = 1'b1;
        hit_miss = 1'b1;
        instr    = bus.PC_F[WORD_SEL_BIT] ? bus.Instr_F1 : bus.Instr_F0;
      end
    end
  end

  // Controller state and saturating statistics. A fill cycle returns to
  // LOOKUP without counting as a hit; the miss was already counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_LOOKUP;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        ST_LOOKUP: begin
          if (hit) begin
            if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_ONE;
          end else begin
            state <= ST_MISS_WAIT;
            if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_ONE;
          end
        end
        default: begin
          if (bus.countdone) state <= ST_LOOKUP;
        end
      endcase
    end
  end

  assign bus.hit_miss = hit_miss;
  assign bus.StallF   = ~hit_miss;
  assign bus.Instr_F  = instr;
  assign bus.hit_cnt  = hit_cnt;
  assign bus.miss_cnt = miss_cnt;

endmodule
